qkd_event_pingpong_writer: RTL and testbench

Writes receiver detection events into the two on-chip event buffers (mem1, mem2) that the SoC shares with the HPS. It runs as a ping-pong writer:
- one buffer is filled while the other is held for software readout;
- handoff uses full flags, word counts and release strobes;
- the upstream detector logic feeds it one packed event per strobe.

---
 rtl/qkd_event_pingpong_writer_pkg.sv | 20 ++
 rtl/qkd_buf_port.sv | 76 +++++++
 rtl/qkd_event_pingpong_writer.sv | 143 ++++++++++++++
 tb/tb_qkd_event_pingpong_writer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/qkd_event_pingpong_writer_pkg.sv
// Shared definitions for the QKD event ping-pong writer: event word layout,
// buffer geometry and the fill-state encoding.
package qkd_pkg;

    localparam int ADDR_W    = 13;
    localparam int DEPTH     = 8192;
    localparam int DATA_W    = 16;
    localparam int SLOT_W    = DATA_W - 2;

    localparam int BASIS_BIT = 15;
    localparam int VALUE_BIT = 14;
    localparam int SLOT_LSB  = 0;

    typedef enum logic [1:0] {
        FILL_A    = 2'd0,
        FILL_B    = 2'd1,
        NONE_FREE = 2'd2
    } state_t;

endpackage

// File: rtl/qkd_buf_port.sv
// One event buffer: word count, full flag, software release and the
// registered Avalon-style write port into the shared on-chip memory.
module qkd_buf_port
    import qkd_pkg::*;
#(
    parameter int ADDR_W = qkd_pkg::ADDR_W,
    parameter int DEPTH  = qkd_pkg::DEPTH,
    parameter int DATA_W = qkd_pkg::DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_write,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_close,
    input  logic              i_release,
    output logic              o_full,
    output logic [ADDR_W:0]   o_count,
    output logic              o_last,
    output logic              o_rel,
    output logic [ADDR_W-1:0] o_address,
    output logic              o_clken,
    output logic              o_chipselect,
    output logic              o_write,
    output logic [DATA_W-1:0] o_writedata,
    output logic [1:0]        o_byteenable
);

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

    logic              r_full;
    logic [ADDR_W:0]   r_count;
    logic              r_write;
    logic [ADDR_W-1:0] r_address;
    logic [DATA_W-1:0] r_writedata;
    logic              w_rel;

    // A release only counts against a buffer software actually owns.
    assign w_rel = i_release & r_full;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_full      <= 1'b0;
            r_count     <= '0;
            r_write     <= 1'b0;
            r_address   <= '0;
            r_writedata <= '0;
        end else begin
            r_write     <= i_write;
            r_address   <= i_write ? r_count[ADDR_W-1:0] : '0;
            r_writedata <= i_write ? i_data : '0;
            if (w_rel) begin
                r_full  <= 1'b0;
                r_count <= '0;
            end else begin
                if (i_write) begin
                    r_count <= r_count + (ADDR_W+1)'(1);
                end
                if (i_close) begin
                    r_full <= 1'b1;
                end
            end
        end
    end

    assign o_full       = r_full;
    assign o_count      = r_count;
    assign o_last       = (r_count == LAST_IDX);
    assign o_rel        = w_rel;
    assign o_address    = r_address;
    assign o_clken      = 1'b1;
    assign o_chipselect = r_write;
    assign o_write      = r_write;
    assign o_writedata  = r_writedata;
    assign o_byteenable = {2{r_write}};

endmodule

// File: rtl/qkd_event_pingpong_writer.sv
// Ping-pong writer of detection events into mem1/mem2: fills one buffer while
// software drains the other; closes on full or flush, drops events when neither is free.
module qkd_event_pingpong_writer
    import qkd_pkg::*;
#(
    parameter int ADDR_W = qkd_pkg::ADDR_W,
    parameter int DEPTH  = qkd_pkg::DEPTH,
    parameter int SLOT_W = qkd_pkg::SLOT_W,
    parameter int DATA_W = qkd_pkg::DATA_W
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              ev_strobe,
    input  logic              ev_basis,
    input  logic              ev_bit,
    input  logic [SLOT_W-1:0] ev_slot,
    input  logic              flush,
    input  logic [1:0]        buf_release,
    output logic [1:0]        buf_full,
    output logic [ADDR_W:0]   buf_count0,
    output logic [ADDR_W:0]   buf_count1,
    output logic [1:0]        active_buf,
    output logic [15:0]       overflow_cnt,
    output logic [ADDR_W-1:0] mem1_s1_address,
    output logic              mem1_s1_clken,
    output logic              mem1_s1_chipselect,
    output logic              mem1_s1_write,
    output logic [DATA_W-1:0] mem1_s1_writedata,
    output logic [1:0]        mem1_s1_byteenable,
    output logic [ADDR_W-1:0] mem2_s1_address,
    output logic              mem2_s1_clken,
    output logic              mem2_s1_chipselect,
    output logic              mem2_s1_write,
    output logic [DATA_W-1:0] mem2_s1_writedata,
    output logic [1:0]        mem2_s1_byteenable
);

    state_t            r_state;
    state_t            w_state_next;
    logic [15:0]       r_overflow;
    logic [DATA_W-1:0] w_event;
    logic [1:0]        w_write;
    logic [1:0]        w_close;
    logic [1:0]        w_last;
    logic [1:0]        w_rel;
    logic              w_drop;

    always_comb begin
        w_event                      = '0;
        w_event[BASIS_BIT]           = ev_basis;
        w_event[VALUE_BIT]           = ev_bit;
        w_event[SLOT_LSB +: SLOT_W]  = ev_slot;
    end

    // A flush with an event in the same cycle still closes an empty buffer,
    // because that event becomes its only word.
    always_comb begin
        w_state_next = r_state;
        w_write      = 2'b00;
        w_close      = 2'b00;
        w_drop       = 1'b0;
        case (r_state)
            FILL_A: begin
                w_write[0] = ev_strobe;
                w_close[0] = (ev_strobe && w_last[0]) ||
                             (flush && (ev_strobe || buf_count0 != '0));
                if (w_close[0]) begin
                    w_state_next = (!buf_full[1] || w_rel[1]) ? FILL_B : NONE_FREE;
                end
            end
            FILL_B: begin
                w_write[1] = ev_strobe;
                w_close[1] = (ev_strobe && w_last[1]) ||
                             (flush && (ev_strobe || buf_count1 != '0));
                if (w_close[1]) begin
                    w_state_next = (!buf_full[0] || w_rel[0]) ? FILL_A : NONE_FREE;
                end
            end
            default: begin
                w_drop = ev_strobe;
                if (w_rel[0]) begin
                    w_state_next = FILL_A;
                end else if (w_rel[1]) begin
                    w_state_next = FILL_B;
                end
            end
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state    <= FILL_A;
            r_overflow <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_drop && r_overflow != 16'hFFFF) begin
                r_overflow <= r_overflow + 16'd1;
            end
        end
    end

    assign active_buf   = {r_state == FILL_B, r_state == FILL_A};
    assign overflow_cnt = r_overflow;

    qkd_buf_port #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) u_port1 (
        .i_clk        (clk_clk),
        .i_rst_n      (reset_reset_n),
        .i_write      (w_write[0]),
        .i_data       (w_event),
        .i_close      (w_close[0]),
        .i_release    (buf_release[0]),
        .o_full       (buf_full[0]),
        .o_count      (buf_count0),
        .o_last       (w_last[0]),
        .o_rel        (w_rel[0]),
        .o_address    (mem1_s1_address),
        .o_clken      (mem1_s1_clken),
        .o_chipselect (mem1_s1_chipselect),
        .o_write      (mem1_s1_write),
        .o_writedata  (mem1_s1_writedata),
        .o_byteenable (mem1_s1_byteenable)
    );

    qkd_buf_port #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W)) u_port2 (
        .i_clk        (clk_clk),
        .i_rst_n      (reset_reset_n),
        .i_write      (w_write[1]),
        .i_data       (w_event),
        .i_close      (w_close[1]),
        .i_release    (buf_release[1]),
        .o_full       (buf_full[1]),
        .o_count      (buf_count1),
        .o_last       (w_last[1]),
        .o_rel        (w_rel[1]),
        .o_address    (mem2_s1_address),
        .o_clken      (mem2_s1_clken),
        .o_chipselect (mem2_s1_chipselect),
        .o_write      (mem2_s1_write),
        .o_writedata  (mem2_s1_writedata),
        .o_byteenable (mem2_s1_byteenable)
    );

endmodule

// File: tb/tb_qkd_event_pingpong_writer.sv
// Directed-plus-random bench for the ping-pong event writer, checked every
// cycle against a buffer-level model (active buffer, counts, full flags, drops).
module tb_qkd_event_pingpong_writer;

    localparam int DEPTH = 8192;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic        ev_strobe, ev_basis, ev_bit, flush;
    logic [13:0] ev_slot;
    logic [1:0]  buf_release;
    logic [1:0]  buf_full, active_buf;
    logic [13:0] buf_count0, buf_count1;
    logic [15:0] overflow_cnt;
    logic [12:0] mem1_s1_address, mem2_s1_address;
    logic        mem1_s1_clken, mem1_s1_chipselect, mem1_s1_write;
    logic        mem2_s1_clken, mem2_s1_chipselect, mem2_s1_write;
    logic [15:0] mem1_s1_writedata, mem2_s1_writedata;
    logic [1:0]  mem1_s1_byteenable, mem2_s1_byteenable;

    int n_pass  = 0;
    int n_total = 0;

    // Model: m_act is 0 (mem1), 1 (mem2) or 2 (no buffer free).
    int m_act;
    bit m_full [2];
    int m_cnt  [2];
    int m_ovf;
    bit exp_wr   [2];
    int exp_addr [2];
    int exp_data [2];

    qkd_event_pingpong_writer dut (
        .clk_clk            (clk_clk),
        .reset_reset_n      (reset_reset_n),
        .ev_strobe          (ev_strobe),
        .ev_basis           (ev_basis),
        .ev_bit             (ev_bit),
        .ev_slot            (ev_slot),
        .flush              (flush),
        .buf_release        (buf_release),
        .buf_full           (buf_full),
        .buf_count0         (buf_count0),
        .buf_count1         (buf_count1),
        .active_buf         (active_buf),
        .overflow_cnt       (overflow_cnt),
        .mem1_s1_address    (mem1_s1_address),
        .mem1_s1_clken      (mem1_s1_clken),
        .mem1_s1_chipselect (mem1_s1_chipselect),
        .mem1_s1_write      (mem1_s1_write),
        .mem1_s1_writedata  (mem1_s1_writedata),
        .mem1_s1_byteenable (mem1_s1_byteenable),
        .mem2_s1_address    (mem2_s1_address),
        .mem2_s1_clken      (mem2_s1_clken),
        .mem2_s1_chipselect (mem2_s1_chipselect),
        .mem2_s1_write      (mem2_s1_write),
        .mem2_s1_writedata  (mem2_s1_writedata),
        .mem2_s1_byteenable (mem2_s1_byteenable)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
    endtask

    task automatic model_reset();
        m_act = 0;
        m_ovf = 0;
        for (int x = 0; x < 2; x++) begin
            m_full[x] = 1'b0;
            m_cnt[x]  = 0;
            exp_wr[x] = 1'b0;
        end
    endtask

    task automatic model_step(input logic s, input logic [15:0] word, input logic f, input logic [1:0] r);
        bit rel [2];
        int a;
        int o;
        for (int x = 0; x < 2; x++) begin
            rel[x]    = r[x] && m_full[x];
            exp_wr[x] = 1'b0;
        end
        if (m_act == 2) begin
            if (s && m_ovf < 65535) m_ovf++;
            if (rel[0]) m_act = 0;
            else if (rel[1]) m_act = 1;
        end else begin
            a = m_act;
            o = 1 - a;
            if (s) begin
                exp_wr[a]   = 1'b1;
                exp_addr[a] = m_cnt[a];
                exp_data[a] = int'(word);
                m_cnt[a]++;
            end
            if (m_cnt[a] == DEPTH || (f && m_cnt[a] > 0)) begin
                m_full[a] = 1'b1;
                m_act = (!m_full[o] || rel[o]) ? o : 2;
            end
        end
        for (int x = 0; x < 2; x++) begin
            if (rel[x]) begin
                m_full[x] = 1'b0;
                m_cnt[x]  = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("mem1_write", mem1_s1_write, exp_wr[0]);
        chk("mem1_cs", mem1_s1_chipselect, exp_wr[0]);
        chk("mem1_be", mem1_s1_byteenable, exp_wr[0] ? 2'b11 : 2'b00);
        chk("mem1_clken", mem1_s1_clken, 1);
        if (exp_wr[0]) begin
            chk("mem1_addr", mem1_s1_address, exp_addr[0]);
            chk("mem1_data", mem1_s1_writedata, exp_data[0]);
        end
        chk("mem2_write", mem2_s1_write, exp_wr[1]);
        chk("mem2_cs", mem2_s1_chipselect, exp_wr[1]);
        chk("mem2_be", mem2_s1_byteenable, exp_wr[1] ? 2'b11 : 2'b00);
        chk("mem2_clken", mem2_s1_clken, 1);
        if (exp_wr[1]) begin
            chk("mem2_addr", mem2_s1_address, exp_addr[1]);
            chk("mem2_data", mem2_s1_writedata, exp_data[1]);
        end
        chk("buf_full", buf_full, {m_full[1], m_full[0]});
        chk("count0", buf_count0, m_cnt[0]);
        chk("count1", buf_count1, m_cnt[1]);
        chk("active_buf", active_buf, (m_act == 0) ? 1 : (m_act == 1) ? 2 : 0);
        chk("overflow_cnt", overflow_cnt, m_ovf);
    endtask

    // One clock: drive at edge+1, let the next edge sample, check at edge+1.
    task automatic cyc(input logic s, input logic f, input logic [1:0] r,
                       input logic b, input logic v, input logic [13:0] sl);
        ev_strobe   = s;
        ev_basis    = b;
        ev_bit      = v;
        ev_slot     = sl;
        flush       = f;
        buf_release = r;
        @(posedge clk_clk);
        model_step(s, {b, v, sl}, f, r);
        #1;
        ev_strobe   = 1'b0;
        flush       = 1'b0;
        buf_release = 2'b00;
        check_all();
    endtask

    task automatic rcyc(input logic s, input logic f, input logic [1:0] r);
        cyc(s, f, r, 1'($urandom), 1'($urandom), 14'($urandom));
    endtask

    initial begin
        reset_reset_n = 1'b0;
        ev_strobe = 1'b0; ev_basis = 1'b0; ev_bit = 1'b0; ev_slot = '0;
        flush = 1'b0; buf_release = 2'b00;
        model_reset();
        @(posedge clk_clk); #1;
        check_all();
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        @(posedge clk_clk); #1;
        check_all();

        // Three known events into mem1.
        cyc(1, 0, 2'b00, 1, 0, 14'd5);
        chk("ev0_data", mem1_s1_writedata, 32'h8005);
        cyc(1, 0, 2'b00, 1, 0, 14'd6);
        chk("ev1_addr", mem1_s1_address, 1);
        cyc(1, 0, 2'b00, 1, 0, 14'd7);
        chk("ev2_data", mem1_s1_writedata, 32'h8007);
        chk("ev2_count0", buf_count0, 3);

        // Complete mem1 back-to-back, then the next event must hit mem2 at 0.
        for (int i = 3; i < DEPTH; i++) rcyc(1, 0, 2'b00);
        chk("fullA_flags", buf_full, 2'b01);
        chk("fullA_count0", buf_count0, DEPTH);
        chk("fullA_active", active_buf, 2'b10);
        rcyc(1, 0, 2'b00);
        chk("switch_write2", mem2_s1_write, 1);
        chk("switch_addr2", mem2_s1_address, 0);

        // Release mem1, flush mem2 after 10 events, then flush an empty mem1.
        rcyc(0, 0, 2'b01);
        for (int i = 0; i < 9; i++) rcyc(1, 0, 2'b00);
        rcyc(0, 1, 2'b00);
        chk("flush_full", buf_full, 2'b10);
        chk("flush_count1", buf_count1, 10);
        rcyc(0, 1, 2'b00);
        chk("flush_empty_active", active_buf, 2'b01);
        chk("flush_empty_full", buf_full, 2'b10);

        // Fill mem1 too, then drop 5 events.
        for (int i = 0; i < DEPTH; i++) rcyc(1, 0, 2'b00);
        for (int i = 0; i < 5; i++) rcyc(1, 0, 2'b00);
        chk("ovf_cnt5", overflow_cnt, 5);
        chk("ovf_active", active_buf, 2'b00);
        rcyc(0, 0, 2'b10);
        chk("rel2_full", buf_full, 2'b01);
        chk("rel2_active", active_buf, 2'b10);
        rcyc(1, 0, 2'b00);
        chk("rel2_addr", mem2_s1_address, 0);

        // Both full again, then release both with a coincident (dropped) event.
        rcyc(0, 1, 2'b00);
        rcyc(1, 0, 2'b11);
        chk("relboth_active", active_buf, 2'b01);
        chk("relboth_full", buf_full, 2'b00);
        chk("relboth_ovf", overflow_cnt, 6);

        // Random mix of events, flushes and releases.
        for (int i = 0; i < 600; i++) begin
            rcyc($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                 ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b00);
        end

        // Asynchronous reset between edges while an event is being written.
        rcyc(0, 0, 2'b11);
        rcyc(1, 0, 2'b00);
        #2;
        reset_reset_n = 1'b0;
        #1;
        chk("async_mem1_write", mem1_s1_write, 0);
        chk("async_mem2_write", mem2_s1_write, 0);
        model_reset();
        @(posedge clk_clk); #1;
        check_all();
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        @(posedge clk_clk); #1;
        chk("post_rst_count0", buf_count0, 0);
        chk("post_rst_active", active_buf, 2'b01);
        for (int i = 0; i < 4; i++) rcyc(1, 0, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
